// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, opcode values and the default device ID.
// The optional IDCODE register is enabled by defining TAP_IDCODE_EN.
package tap_pkg;

  // Conventional 1149.1 encoding, so tap_state matches common debugger displays.
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR        = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR        = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  // Opcode values; BYPASS is all ones at whatever IR width is chosen.
  localparam int unsigned OPC_EXTEST         = 0;
  localparam int unsigned OPC_SAMPLE_PRELOAD = 1;
  localparam int unsigned OPC_IDCODE         = 2;

  localparam logic [31:0] DEFAULT_IDCODE = 32'h1000_0001;

  function automatic logic is_shift_state(input tap_state_t s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// Pure IEEE 1149.1 TMS state machine; the registered state is the Moore output.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  output tap_state_t state
);

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      case (state)
        TEST_LOGIC_RESET: state <= TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_DR:        state <= TMS ? SELECT_IR        : CAPTURE_DR;
        CAPTURE_DR:       state <= TMS ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state <= TMS ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state <= TMS ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state <= TMS ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state <= TMS ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        SELECT_IR:        state <= TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state <= TMS ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state <= TMS ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state <= TMS ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state <= TMS ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state <= TMS ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state <= TMS ? SELECT_DR        : RUN_TEST_IDLE;
        default:          state <= TEST_LOGIC_RESET;
      endcase
    end
  end

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller top: state machine, instruction register, bypass/IDCODE registers
// and negedge TDO stage. Define TAP_IDCODE_EN to build the IDCODE register.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int unsigned IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = DEFAULT_IDCODE
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  input  logic                bsr_tdo,
  output logic                TDO,
  output logic                tdo_en,
  output logic                dr_capture,
  output logic                dr_shift,
  output logic                dr_update,
  output logic                bsr_select,
  output logic                mode,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic [3:0]          tap_state
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OPC_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OPC_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OPC_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = IR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_DEFAULT = IR_BYPASS;
`endif

  tap_state_t          state;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_act;
  logic                byp;
  logic                sel_bsr;
  logic                sel_idcode;
  logic                sel_bypass;
  logic                id_tdo;
  logic                tdo_mux;
  logic                tdo_q;
  logic                tdo_en_q;

  tap_fsm u_fsm (
    .TCK   (TCK),
    .TRST  (TRST),
    .TMS   (TMS),
    .state (state)
  );

  // Instruction decode; unknown opcodes fall through to BYPASS.
  assign sel_bsr    = (ir_act == IR_EXTEST) || (ir_act == IR_SAMPLE);
`ifdef TAP_IDCODE_EN
  assign sel_idcode = (ir_act == IR_IDCODE);
`else
  assign sel_idcode = 1'b0;
`endif
  assign sel_bypass = !sel_bsr && !sel_idcode;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr <= IR_CAPTURE;
    end else begin
      case (state)
        CAPTURE_IR: ir_sr <= IR_CAPTURE;
        SHIFT_IR:   ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
        default:    ir_sr <= ir_sr;
      endcase
    end
  end

  // The default is loaded on the edge that enters TEST_LOGIC_RESET, so it is
  // already active while the controller sits in that state.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_act <= IR_DEFAULT;
    end else if (TMS && (state == TEST_LOGIC_RESET || state == SELECT_IR)) begin
      ir_act <= IR_DEFAULT;
    end else if (state == UPDATE_IR) begin
      ir_act <= ir_sr;
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      byp <= 1'b0;
    end else if (state == CAPTURE_DR) begin
      byp <= 1'b0;
    end else if (state == SHIFT_DR && sel_bypass) begin
      byp <= TDI;
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] id_sr;

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      id_sr <= IDCODE_VAL;
    end else if (state == CAPTURE_DR) begin
      id_sr <= IDCODE_VAL;
    end else if (state == SHIFT_DR && sel_idcode) begin
      id_sr <= {TDI, id_sr[31:1]};
    end
  end

  assign id_tdo = id_sr[0];
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VAL;
  assign id_tdo        = 1'b0;
`endif

  always_comb begin
    tdo_mux = 1'b0;
    case (state)
      SHIFT_IR: tdo_mux = ir_sr[0];
      SHIFT_DR: begin
        if (sel_bsr)         tdo_mux = bsr_tdo;
        else if (sel_idcode) tdo_mux = id_tdo;
        else                 tdo_mux = byp;
      end
      default:  tdo_mux = 1'b0;
    endcase
  end

  // Retime on the falling edge so TDO is stable for the next rising edge downstream.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= is_shift_state(state);
      tdo_q    <= is_shift_state(state) ? tdo_mux : 1'b0;
    end
  end

  assign TDO        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign dr_capture = (state == CAPTURE_DR) || (state == SHIFT_DR);
  assign dr_shift   = (state == SHIFT_DR);
  assign dr_update  = (state == UPDATE_DR);
  assign bsr_select = sel_bsr;
  assign mode       = (ir_act == IR_EXTEST);
  assign ir_out     = ir_act;
  assign tap_state  = state;

endmodule

// File: tb/tb_tap_ctrl.sv
// Self-checking bench for tap_ctrl: directed scans plus random TMS/TDI against
// a table-driven behavioural model of the TAP, IR and data registers.
module tb_tap_ctrl;

  localparam int          W   = 4;
  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam logic [W-1:0] DEF_IR = 4'b0010;
`else
  localparam logic [W-1:0] DEF_IR = 4'b1111;
`endif

  logic         TCK = 1'b0;
  logic         TRST = 1'b0;
  logic         TMS = 1'b1;
  logic         TDI = 1'b0;
  logic         bsr_tdo = 1'b0;
  logic         TDO, tdo_en, dr_capture, dr_shift, dr_update, bsr_select, mode;
  logic [W-1:0] ir_out;
  logic [3:0]   tap_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int c_cap, c_sh, c_up;

  always #5 TCK = ~TCK;

  tap_ctrl #(.IR_WIDTH(W), .IDCODE_VAL(IDV)) dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .TDI        (TDI),
    .bsr_tdo    (bsr_tdo),
    .TDO        (TDO),
    .tdo_en     (tdo_en),
    .dr_capture (dr_capture),
    .dr_shift   (dr_shift),
    .dr_update  (dr_update),
    .bsr_select (bsr_select),
    .mode       (mode),
    .ir_out     (ir_out),
    .tap_state  (tap_state)
  );

  // ---------------- behavioural model ----------------
  typedef enum int {M_TLR, M_RTI, M_SDR, M_CDR, M_SHDR, M_E1DR, M_PDR, M_E2DR, M_UDR,
                    M_SIR, M_CIR, M_SHIR, M_E1IR, M_PIR, M_E2IR, M_UIR} mst_t;
  mst_t nx0 [16] = '{M_RTI, M_RTI, M_CDR, M_SHDR, M_SHDR, M_PDR, M_PDR, M_SHDR, M_RTI,
                     M_CIR, M_SHIR, M_SHIR, M_PIR, M_PIR, M_SHIR, M_RTI};
  mst_t nx1 [16] = '{M_TLR, M_SDR, M_SIR, M_E1DR, M_E1DR, M_UDR, M_E2DR, M_UDR, M_SDR,
                     M_TLR, M_E1IR, M_E1IR, M_UIR, M_E2IR, M_UIR, M_SDR};

  mst_t         m_st;
  logic [W-1:0] m_ir_sr, m_ir;
  logic         m_byp, m_tdo, m_tdo_en;
  logic [31:0]  m_id;

  // 0 = boundary scan, 1 = IDCODE, 2 = bypass
  function automatic int m_cls(input logic [W-1:0] ir);
    if (ir == 0 || ir == 1) return 0;
`ifdef TAP_IDCODE_EN
    if (ir == 2) return 1;
`endif
    return 2;
  endfunction

  task automatic m_reset();
    m_st = M_TLR; m_ir_sr = 1; m_ir = DEF_IR; m_byp = 0; m_id = IDV;
    m_tdo = 0; m_tdo_en = 0;
  endtask

  task automatic m_pos(input logic tms, input logic tdi);
    case (m_st)
      M_CIR:  m_ir_sr = 1;
      M_SHIR: m_ir_sr = {tdi, m_ir_sr[W-1:1]};
      M_UIR:  m_ir = m_ir_sr;
      M_CDR:  begin m_byp = 0; m_id = IDV; end
      M_SHDR: begin
        if (m_cls(m_ir) == 2) m_byp = tdi;
        if (m_cls(m_ir) == 1) m_id = {tdi, m_id[31:1]};
      end
      default: ;
    endcase
    m_st = tms ? nx1[m_st] : nx0[m_st];
    if (m_st == M_TLR) m_ir = DEF_IR;
  endtask

  task automatic m_neg();
    m_tdo_en = (m_st == M_SHIR) || (m_st == M_SHDR);
    if (m_st == M_SHIR)      m_tdo = m_ir_sr[0];
    else if (m_st == M_SHDR) m_tdo = (m_cls(m_ir) == 0) ? bsr_tdo :
                                     (m_cls(m_ir) == 1) ? m_id[0] : m_byp;
    else                     m_tdo = 0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge TCK) begin
    if (cmp_en) begin
      #2;
      chk("tlr",        64'(tap_state == 4'hF), 64'(m_st == M_TLR));
      chk("dr_capture", 64'(dr_capture), 64'(m_st == M_CDR || m_st == M_SHDR));
      chk("dr_shift",   64'(dr_shift),   64'(m_st == M_SHDR));
      chk("dr_update",  64'(dr_update),  64'(m_st == M_UDR));
      chk("ir_out",     64'(ir_out),     64'(m_ir));
      chk("bsr_select", 64'(bsr_select), 64'(m_cls(m_ir) == 0));
      chk("mode",       64'(mode),       64'(m_ir == 0));
      chk("tdo_en",     64'(tdo_en),     64'(m_tdo_en));
      chk("tdo",        64'(TDO),        64'(m_tdo));
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi; bsr_tdo = 1'($urandom_range(0, 1));
    @(posedge TCK); m_pos(tms, tdi);
    @(negedge TCK); m_neg();
    #3;
    c_cap += int'(dr_capture); c_sh += int'(dr_shift); c_up += int'(dr_update);
  endtask

  task automatic do_reset();
    TRST = 1'b0; m_reset();
    repeat (2) @(negedge TCK);
    #3; TRST = 1'b1;
  endtask

  task automatic to_idle();
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // Starts and ends in RUN_TEST_IDLE; obs holds TDO while in SHIFT_IR.
  task automatic load_ir(input logic [W-1:0] v, output logic [W-1:0] obs);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    obs[0] = TDO;
    for (int i = 0; i < W; i++) begin
      tick(i == W - 1, v[i]);
      if (i < W - 1) obs[i+1] = TDO;
    end
    tick(1, 0); tick(0, 0);
  endtask

  // Starts and ends in RUN_TEST_IDLE; n shift edges, obs holds n TDO bits.
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] obs);
    obs = '0; c_cap = 0; c_sh = 0; c_up = 0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    obs[0] = TDO;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i]);
      if (i < n - 1) obs[i+1] = TDO;
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0]  iobs;
    logic [63:0]   dobs, din;
    m_reset();
    #23;
    chk("rst_state",  64'(tap_state), 64'hF);
    chk("rst_tdo",    64'(TDO), 0);
    chk("rst_tdo_en", 64'(tdo_en), 0);
    chk("rst_ir_out", 64'(ir_out), 64'(DEF_IR));
    chk("rst_bsrsel", 64'(bsr_select), 0);
    chk("rst_dr",     64'({dr_capture, dr_shift, dr_update, mode}), 0);
    cmp_en = 1'b1;
    TRST = 1'b1;

    // Into SHIFT_DR, then five TMS=1 edges back to reset.
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    repeat (5) tick(1, 0);
    chk("tlr5_state",  64'(tap_state), 64'hF);
    chk("tlr5_ir_out", 64'(ir_out), 64'(DEF_IR));
    chk("tlr5_bsrsel", 64'(bsr_select), 0);

    // Load EXTEST.
    tick(0, 0);
    load_ir(4'b0000, iobs);
    chk("ir_capture_tdo", 64'(iobs), 64'(4'b0001));
    chk("extest_mode",    64'(mode), 1);
    chk("extest_bsrsel",  64'(bsr_select), 1);

    // EXTEST DR scan of 14 bits.
    din = {$urandom, $urandom};
    dr_scan(14, din, dobs);
    chk("cnt_capture", 64'(c_cap), 15);
    chk("cnt_shift",   64'(c_sh), 14);
    chk("cnt_update",  64'(c_up), 1);

    // BYPASS: one-bit delay, first captured bit 0.
    load_ir(4'b1111, iobs);
    chk("byp_ir_out", 64'(ir_out), 64'(4'b1111));
    chk("byp_mode",   64'(mode), 0);
    dr_scan(5, 64'b01101, dobs);
    chk("byp_tdo", 64'(dobs[4:0]), 64'(5'b11010));

    // Default instruction after reset: IDCODE if built, otherwise BYPASS.
    do_reset();
    tick(0, 0);
    din = {32'h0, $urandom};
    dr_scan(32, din, dobs);
`ifdef TAP_IDCODE_EN
    chk("idcode_tdo", dobs[31:0], 64'h1000_0001);
`else
    chk("idcode_tdo", dobs[31:0], {32'h0, din[30:0], 1'b0});
`endif

    // Random walk with occasional IR loads, DR scans and resets.
    for (int k = 0; k < 1500; k++) begin
      int r;
      r = $urandom_range(0, 59);
      if (r == 0) begin
        to_idle();
        load_ir(W'($urandom_range(0, (1 << W) - 1)), iobs);
        chk("rnd_ir_tdo", 64'(iobs), 64'(1));
      end else if (r == 1) begin
        to_idle();
        dr_scan($urandom_range(1, 40), {$urandom, $urandom}, dobs);
      end else if (r == 2) begin
        do_reset();
      end else begin
        tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end
    end

    // Asynchronous reset while shifting DR.
    to_idle();
    load_ir(4'b1111, iobs);
    tick(1, 0); tick(0, 0); tick(0, 1);
    chk("pre_async_tdo_en", 64'(tdo_en), 1);
    TRST = 1'b0; m_reset();
    #1;
    chk("async_tdo",      64'(TDO), 0);
    chk("async_tdo_en",   64'(tdo_en), 0);
    chk("async_dr_shift", 64'(dr_shift), 0);
    chk("async_state",    64'(tap_state), 64'hF);
    repeat (2) @(negedge TCK);
    #3; TRST = 1'b1;
    tick(0, 0);
    chk("post_async_ir", 64'(ir_out), 64'(DEF_IR));

    cmp_en = 1'b0;
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
